// File: rtl/debounce_pkg.sv
// debounce_pkg: channel states and default parameters shared by the switch debouncer
package debounce_pkg;
    typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} deb_state_t;
    localparam int DEB_SYNC_STAGES = 2;
    localparam int DEB_CNT_MAX = 1000;
endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: synchroniser plus qualify-by-count FSM for one raw switch input
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = DEB_SYNC_STAGES,
    parameter int CNT_MAX = DEB_CNT_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic busy,
    output logic glitch
);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CMAX = CW'(CNT_MAX);
    logic [SYNC_STAGES-1:0] sync;
    logic s;
    deb_state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    assign s = sync[SYNC_STAGES-1];
    // a bounce is checked before the count so it wins even at CNT_MAX
    always_comb begin
        state_nxt = state;
        cnt_nxt = '0;
        glitch = 1'b0;
        case (state)
            STABLE_LO: begin
                state_nxt = s ? WAIT_HI : STABLE_LO;
                cnt_nxt = s ? CW'(1) : '0;
            end
            WAIT_HI: begin
                if (!s) begin
                    state_nxt = STABLE_LO;
                    glitch = 1'b1;
                end else if (cnt == CMAX) state_nxt = STABLE_HI;
                else cnt_nxt = cnt + CW'(1);
            end
            STABLE_HI: begin
                state_nxt = s ? STABLE_HI : WAIT_LO;
                cnt_nxt = s ? '0 : CW'(1);
            end
            WAIT_LO: begin
                if (s) begin
                    state_nxt = STABLE_HI;
                    glitch = 1'b1;
                end else if (cnt == CMAX) state_nxt = STABLE_LO;
                else cnt_nxt = cnt + CW'(1);
            end
            default: state_nxt = STABLE_LO;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            state <= STABLE_LO;
            cnt <= '0;
            level <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
            busy <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
            state <= state_nxt;
            cnt <= cnt_nxt;
            level <= state_nxt inside {STABLE_HI, WAIT_LO};
            rise <= state == WAIT_HI && state_nxt == STABLE_HI;
            fall <= state == WAIT_LO && state_nxt == STABLE_LO;
            busy <= state_nxt inside {WAIT_HI, WAIT_LO};
        end
    end
endmodule

// File: rtl/debounce_pair.sv
// debounce_pair: two debounced switch levels with edge pulses and settled flag; DEBOUNCE_GLITCH_CNT_EN adds glitch_cnt
module debounce_pair
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = DEB_SYNC_STAGES,
    parameter int CNT_MAX = DEB_CNT_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_a_raw,
    input  logic sw_b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall,
    output logic settled
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);
    logic busy_a, busy_b, glitch_a, glitch_b;
    debounce_chan #(.SYNC_STAGES(SYNC_STAGES), .CNT_MAX(CNT_MAX)) u_chan_a (
        .clk(clk), .rst_n(rst_n), .raw(sw_a_raw), .level(a), .rise(a_rise),
        .fall(a_fall), .busy(busy_a), .glitch(glitch_a)
    );
    debounce_chan #(.SYNC_STAGES(SYNC_STAGES), .CNT_MAX(CNT_MAX)) u_chan_b (
        .clk(clk), .rst_n(rst_n), .raw(sw_b_raw), .level(b), .rise(b_rise),
        .fall(b_fall), .busy(busy_b), .glitch(glitch_b)
    );
    assign settled = !(busy_a || busy_b);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [8:0] glitch_sum;
    assign glitch_sum = {1'b0, glitch_cnt} + {8'd0, glitch_a} + {8'd0, glitch_b};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) glitch_cnt <= '0;
        else glitch_cnt <= glitch_sum[8] ? 8'hff : glitch_sum[7:0];
    end
`else
    logic unused_glitch;
    assign unused_glitch = glitch_a ^ glitch_b;
`endif
endmodule

// File: tb/tb_debounce_pair.sv
// tb_debounce_pair: directed table and corner sequences for debounce_pair with SYNC_STAGES=2, CNT_MAX=4
`timescale 1ns/100ps
module tb_debounce_pair;
    logic clk, rst_n, ra, rb;
    logic a, b, a_rise, a_fall, b_rise, b_fall, settled;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif
    logic [6:0] ov;
    int n_chk = 0, n_fail = 0;
    int nf, nr, first_lo, bad;
    typedef struct packed {
        logic ra;
        logic rb;
        logic [6:0] exp;
    } vec_t;
    vec_t tbl [15];

    debounce_pair #(.SYNC_STAGES(2), .CNT_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .sw_a_raw(ra), .sw_b_raw(rb),
        .a(a), .b(b), .a_rise(a_rise), .a_fall(a_fall),
        .b_rise(b_rise), .b_fall(b_fall), .settled(settled)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        , .glitch_cnt(glitch_cnt)
`endif
    );

    assign ov = {a, b, a_rise, a_fall, b_rise, b_fall, settled};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_mon();
        step();
        nf += int'(a_fall);
        nr += int'(a_rise);
    endtask

    initial begin
        // fields: ra, rb | a, b, a_rise, a_fall, b_rise, b_fall, settled
        tbl[0]  = '{1'b1, 1'b0, 7'b0000001};
        tbl[1]  = '{1'b1, 1'b0, 7'b0000001};
        tbl[2]  = '{1'b1, 1'b0, 7'b0000000};
        tbl[3]  = '{1'b1, 1'b0, 7'b0000000};
        tbl[4]  = '{1'b1, 1'b0, 7'b0000000};
        tbl[5]  = '{1'b1, 1'b0, 7'b0000000};
        tbl[6]  = '{1'b1, 1'b0, 7'b1010001};
        tbl[7]  = '{1'b1, 1'b0, 7'b1000001};
        tbl[8]  = '{1'b1, 1'b1, 7'b1000001};
        tbl[9]  = '{1'b1, 1'b1, 7'b1000001};
        tbl[10] = '{1'b1, 1'b1, 7'b1000000};
        tbl[11] = '{1'b1, 1'b0, 7'b1000000};
        tbl[12] = '{1'b1, 1'b0, 7'b1000000};
        tbl[13] = '{1'b1, 1'b0, 7'b1000001};
        tbl[14] = '{1'b1, 1'b0, 7'b1000001};

        rst_n = 1'b0;
        ra = 1'b0;
        rb = 1'b0;
        repeat (3) step();
        chk("reset_state", int'(ov), 7'b0000001);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        chk("reset_glitch_cnt", int'(glitch_cnt), 0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            ra = tbl[i].ra;
            rb = tbl[i].rb;
            step();
            chk($sformatf("vec[%0d]", i), int'(ov), int'(tbl[i].exp));
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        chk("glitch_after_bounce", int'(glitch_cnt), 1);
`endif

        nf = 0;
        nr = 0;
        for (int p = 0; p < 4; p++) begin
            ra = (p % 2 == 1);
            repeat (2) step_mon();
        end
        ra = 1'b0;
        first_lo = 0;
        for (int k = 1; k <= 10; k++) begin
            step_mon();
            if (!a && first_lo == 0) first_lo = k;
        end
        chk("toggle_fall_edge", first_lo, 7);
        chk("toggle_fall_count", nf, 1);
        chk("toggle_rise_count", nr, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        chk("glitch_after_toggle", int'(glitch_cnt), 3);
`endif

        ra = 1'b1;
        rb = 1'b1;
        repeat (6) step();
        chk("both_before", int'({a, b}), 0);
        step();
        chk("both_rise", int'({a, b, a_rise, b_rise}), 4'hf);

        ra = 1'b0;
        repeat (10) step();
        chk("pre_reset_levels", int'({a, b}), 2'b01);
        ra = 1'b1;
        repeat (5) step();
        chk("pre_reset_wait", int'(ov), 7'b0100000);
        #1 rst_n = 1'b0;
        #0.5;
        chk("async_reset", int'(ov), 7'b0000001);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        chk("async_reset_glitch", int'(glitch_cnt), 0);
`endif
        #0.5 rst_n = 1'b1;
        bad = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (ov[6:2] != 5'b0) bad++;
        end
        chk("post_reset_quiet", bad, 0);
        step();
        chk("post_reset_rise", int'({a, b, a_rise, b_rise}), 4'hf);

`ifdef DEBOUNCE_GLITCH_CNT_EN
        ra = 1'b0;
        rb = 1'b0;
        repeat (12) step();
        chk("sat_start", int'(glitch_cnt), 0);
        for (int i = 0; i < 300; i++) begin
            rb = 1'b1;
            step();
            rb = 1'b0;
            repeat (3) step();
            if (i == 99) chk("glitch_100", int'(glitch_cnt), 100);
        end
        chk("glitch_saturate", int'(glitch_cnt), 255);
        chk("sat_b_level", int'(b), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
